// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-load/serial-shift sequencers:
// controller state encoding and a counter-width helper.
package p2s_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SH_LO = 3'd2,
        S_SH_HI = 3'd3,
        S_LATCH = 3'd4,
        S_DONE  = 3'd5
    } p2s_state_t;

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/p2s_shift_core.sv
// Parallel-load / serial-shift register: SL=1 loads p_in, SL=0 shifts left
// with s_in entering bit 0, en=0 holds.
module p2s_shift_core #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              SL,
    input  logic              s_in,
    input  logic [DATA_W-1:0] p_in,
    output logic [DATA_W-1:0] Q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            Q <= '0;
        else if (en)
            Q <= SL ? p_in : {Q[DATA_W-2:0], s_in};
    end

endmodule

// File: rtl/p2s_shift_ctrl.sv
// Frame sequencer: captures NUM_WORDS words on start, then loads and shifts
// each word MSB-first on a divided serial clock, ending with a latch strobe.
module p2s_shift_ctrl
    import p2s_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 2,
    parameter int CLK_DIV   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATA_W*NUM_WORDS-1:0] data_in,
    output logic                        busy,
    output logic                        done,
    output logic                        ser_clk,
    output logic                        ser_data,
    output logic                        ser_latch
);

    localparam int DIV_W = clog2_min1(CLK_DIV);
    localparam int BIT_W = clog2_min1(DATA_W + 1);
    localparam int IDX_W = clog2_min1(NUM_WORDS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

    p2s_state_t                       state, state_n;
    logic [NUM_WORDS-1:0][DATA_W-1:0] frame;
    logic [DIV_W-1:0]                 div_cnt;
    logic [BIT_W-1:0]                 bit_cnt;
    logic [IDX_W-1:0]                 word_idx;
    logic                             sr_en, sr_sl;
    logic                             div_last, timed;
    logic [DATA_W-2:0]                sr_unused;

    assign div_last = (div_cnt == DIV_LAST);
    assign timed    = (state == S_SH_LO) || (state == S_SH_HI) || (state == S_LATCH);

    always_comb begin
        state_n = state;
        sr_en   = 1'b0;
        sr_sl   = 1'b0;
        case (state)
            S_IDLE:  if (start) state_n = S_LOAD;
            S_LOAD: begin
                sr_en   = 1'b1;
                sr_sl   = 1'b1;
                state_n = S_SH_LO;
            end
            S_SH_LO: if (div_last) state_n = S_SH_HI;
            S_SH_HI: begin
                if (div_last) begin
                    sr_en = 1'b1;
                    if (bit_cnt != BIT_ONE)
                        state_n = S_SH_LO;
                    else if (word_idx == IDX_LAST)
                        state_n = S_LATCH;
                    else
                        state_n = S_LOAD;
                end
            end
            S_LATCH: if (div_last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Outputs are decoded from the next state so they are plain flops that
    // line up exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
        end else begin
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            ser_clk   <= (state_n == S_SH_HI);
            ser_latch <= (state_n == S_LATCH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame    <= '0;
            word_idx <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
        end else begin
            div_cnt <= (timed && state_n == state) ? div_cnt + 1'b1 : '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        frame    <= data_in;
                        word_idx <= '0;
                    end
                end
                S_LOAD: bit_cnt <= BIT_FULL;
                S_SH_HI: begin
                    if (div_last) begin
                        bit_cnt <= bit_cnt - 1'b1;
                        if (bit_cnt == BIT_ONE && word_idx != IDX_LAST)
                            word_idx <= word_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Zeros shift in behind the data, so the register is empty once a word is out.
    p2s_shift_core #(.DATA_W(DATA_W)) u_core (
        .clk  (clk),
        .rst  (rst),
        .en   (sr_en),
        .SL   (sr_sl),
        .s_in (1'b0),
        .p_in (frame[word_idx]),
        .Q    ({ser_data, sr_unused})
    );

endmodule
